// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the single SDRAM command port between the video
// burst reader (always preferred) and the terminal burst writer. Writer bursts
// are split into chunks of at most MAX_WRITE_CHUNK words. This bounds how long
// a video request can be held off.
module sdram_port_arbiter #(
    parameter int MAX_WRITE_CHUNK = 16,
    parameter int ADDR_WIDTH      = 23
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  vid_rd_request,
    input  logic [ADDR_WIDTH-1:0] vid_rd_address,
    input  logic [8:0]            vid_rd_burst_length,
    output logic                  vid_rd_available,
    output logic [31:0]           vid_rd_data,

    input  logic                  wr_request,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [8:0]            wr_burst_length,
    output logic                  wr_data_next,
    input  logic [31:0]           wr_data,
    output logic                  wr_done,

    output logic                  sd_cmd_valid,
    input  logic                  sd_cmd_ready,
    output logic                  sd_cmd_write,
    output logic [ADDR_WIDTH-1:0] sd_cmd_address,
    output logic [8:0]            sd_cmd_length,
    input  logic                  sd_rd_valid,
    input  logic [31:0]           sd_rd_data,
    input  logic                  sd_wr_next,
    output logic [31:0]           sd_wr_data,

    output logic                  err_video_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        VID_CMD,
        VID_DATA,
        WR_CMD,
        WR_DATA
    } state_t;

    localparam logic [8:0] CHUNK_LEN = 9'(MAX_WRITE_CHUNK);

    state_t                state, state_next;
    logic                  vid_pend;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic [8:0]            vid_len;
    logic                  wr_pend;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [8:0]            wr_remaining;
    logic [8:0]            count;
    logic [8:0]            wr_chunk;
    logic                  vid_busy;
    logic                  rd_take;

    // A video burst is still owed to the video port, so another request is an overrun
    assign vid_busy = vid_pend || (state == VID_CMD) || (state == VID_DATA);
    assign rd_take  = sd_rd_valid && (state == VID_DATA);
    assign wr_chunk = (wr_remaining > CHUNK_LEN) ? CHUNK_LEN : wr_remaining;

    // Write data passes straight through, but only while a write chunk is streaming
    assign sd_wr_data = (state == WR_DATA) ? wr_data : 32'd0;

    // Next-state and command-port outputs; video always wins in IDLE
    always_comb begin
        state_next     = state;
        sd_cmd_valid   = 1'b0;
        sd_cmd_write   = 1'b0;
        sd_cmd_address = '0;
        sd_cmd_length  = '0;
        wr_data_next   = 1'b0;
        case (state)
            IDLE: begin
                if (vid_pend)
                    state_next = VID_CMD;
                else if (wr_pend)
                    state_next = WR_CMD;
            end
            VID_CMD: begin
                sd_cmd_valid   = 1'b1;
                sd_cmd_address = vid_addr;
                sd_cmd_length  = vid_len;
                if (sd_cmd_ready)
                    state_next = VID_DATA;
            end
            VID_DATA: begin
                if (sd_rd_valid && count == 9'd1)
                    state_next = IDLE;
            end
            WR_CMD: begin
                sd_cmd_valid   = 1'b1;
                sd_cmd_write   = 1'b1;
                sd_cmd_address = wr_addr;
                sd_cmd_length  = wr_chunk;
                if (sd_cmd_ready)
                    state_next = WR_DATA;
            end
            WR_DATA: begin
                wr_data_next = sd_wr_next;
                // Back to IDLE after every chunk so a waiting video burst can cut in
                if (sd_wr_next && count == 9'd1)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, request latches, beat counters and registered read return
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            vid_pend          <= 1'b0;
            vid_addr          <= '0;
            vid_len           <= '0;
            wr_pend           <= 1'b0;
            wr_addr           <= '0;
            wr_remaining      <= '0;
            count             <= '0;
            vid_rd_available  <= 1'b0;
            vid_rd_data       <= '0;
            wr_done           <= 1'b0;
            err_video_overrun <= 1'b0;
        end else begin
            state            <= state_next;
            wr_done          <= 1'b0;
            vid_rd_available <= rd_take;
            if (rd_take)
                vid_rd_data <= sd_rd_data;

            case (state)
                VID_CMD: begin
                    if (sd_cmd_ready) begin
                        vid_pend <= 1'b0;
                        count    <= vid_len;
                    end
                end
                VID_DATA: begin
                    if (sd_rd_valid)
                        count <= count - 9'd1;
                end
                WR_CMD: begin
                    if (sd_cmd_ready)
                        count <= wr_chunk;
                end
                WR_DATA: begin
                    if (sd_wr_next) begin
                        count        <= count - 9'd1;
                        wr_remaining <= wr_remaining - 9'd1;
                        wr_addr      <= wr_addr + ADDR_WIDTH'(1);
                        if (count == 9'd1 && wr_remaining == 9'd1) begin
                            wr_pend <= 1'b0;
                            wr_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Zero-length requests are ignored outright, busy ones are dropped
            if (vid_rd_request && vid_rd_burst_length != 9'd0) begin
                if (vid_busy) begin
                    err_video_overrun <= 1'b1;
                end else begin
                    vid_pend <= 1'b1;
                    vid_addr <= vid_rd_address;
                    vid_len  <= vid_rd_burst_length;
                end
            end

            // wr_pend stays set for the whole burst, so no field below is in use when loaded
            if (wr_request && wr_burst_length != 9'd0 && !wr_pend) begin
                wr_pend      <= 1'b1;
                wr_addr      <= wr_address;
                wr_remaining <= wr_burst_length;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter. A random SDRAM controller model
// returns read data and consumes write beats. Expected command sequences come
// from a chunk-splitting reference model. A monitor pops and compares them.
module tb_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int CH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_rd_request = 1'b0;
    logic [AW-1:0] vid_rd_address = '0;
    logic [8:0]    vid_rd_burst_length = '0;
    logic          vid_rd_available;
    logic [31:0]   vid_rd_data;
    logic          wr_request = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [8:0]    wr_burst_length = '0;
    logic          wr_data_next;
    logic [31:0]   wr_data = '0;
    logic          wr_done;
    logic          sd_cmd_valid;
    logic          sd_cmd_ready = 1'b0;
    logic          sd_cmd_write;
    logic [AW-1:0] sd_cmd_address;
    logic [8:0]    sd_cmd_length;
    logic          sd_rd_valid = 1'b0;
    logic [31:0]   sd_rd_data = '0;
    logic          sd_wr_next = 1'b0;
    logic [31:0]   sd_wr_data;
    logic          err_video_overrun;

    sdram_port_arbiter #(.MAX_WRITE_CHUNK(CH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .vid_rd_request(vid_rd_request), .vid_rd_address(vid_rd_address),
        .vid_rd_burst_length(vid_rd_burst_length), .vid_rd_available(vid_rd_available),
        .vid_rd_data(vid_rd_data),
        .wr_request(wr_request), .wr_address(wr_address), .wr_burst_length(wr_burst_length),
        .wr_data_next(wr_data_next), .wr_data(wr_data), .wr_done(wr_done),
        .sd_cmd_valid(sd_cmd_valid), .sd_cmd_ready(sd_cmd_ready), .sd_cmd_write(sd_cmd_write),
        .sd_cmd_address(sd_cmd_address), .sd_cmd_length(sd_cmd_length),
        .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data),
        .sd_wr_next(sd_wr_next), .sd_wr_data(sd_wr_data),
        .err_video_overrun(err_video_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [8:0]    len;
    } cmd_t;
    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } rd_t;

    cmd_t        exp_cmd[$];
    rd_t         exp_rd[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          rd_owed = 0;
    int          wr_owed = 0;
    int          wr_total_left = 0;
    int unsigned done_due = 0;
    int          exp_done = 0;
    int          cmds_seen = 0;
    int          wr_beats = 0;
    bit          wr_beat_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: split a writer burst into chunks, wrapping the address
    task automatic push_wr(input logic [AW-1:0] a, input int len);
        int          l;
        int          c;
        logic [AW-1:0] ad;
        l  = len;
        ad = a;
        while (l > 0) begin
            c = (l > CH) ? CH : l;
            exp_cmd.push_back('{1'b1, ad, 9'(c)});
            ad = ad + AW'(c);
            l  = l - c;
        end
    endtask

    task automatic push_rd(input logic [AW-1:0] a, input int len);
        exp_cmd.push_back('{1'b0, a, 9'(len)});
    endtask

    task automatic pulse(input bit v, input logic [AW-1:0] va, input int vl,
                         input bit w, input logic [AW-1:0] wa, input int wl);
        @(negedge clk); #1;
        vid_rd_request = v; vid_rd_address = va; vid_rd_burst_length = 9'(vl);
        wr_request = w;     wr_address = wa;     wr_burst_length = 9'(wl);
        @(negedge clk); #1;
        vid_rd_request = 1'b0;
        wr_request = 1'b0;
    endtask

    task automatic start_write(input logic [AW-1:0] a, input int len);
        push_wr(a, len);
        exp_done++;
        wr_total_left = len;
    endtask

    task automatic wait_cmds(input int target);
        int n;
        n = 0;
        while (cmds_seen < target && n < 3000) begin
            @(negedge clk); #3;
            n++;
        end
        check("wait_cmd_timeout", (n < 3000), 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_rd.size() != 0 || exp_done != 0 ||
                rd_owed != 0 || wr_owed != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, (n < 4000), 1);
        repeat (6) @(negedge clk);
    endtask

    // SDRAM controller model: random ready, random gaps, stray strobes while idle
    initial forever begin
        @(negedge clk); #1;
        if (reset) begin
            sd_cmd_ready = 1'b0; sd_rd_valid = 1'b0; sd_wr_next = 1'b0;
            wr_beat_exp = 1'b0; rd_owed = 0; wr_owed = 0; wr_total_left = 0;
        end else begin
            sd_rd_valid = 1'b0;
            if (rd_owed > 0) begin
                if ($urandom_range(3) != 0) begin
                    sd_rd_valid = 1'b1;
                    sd_rd_data  = $urandom;
                    exp_rd.push_back('{sd_rd_data, cyc + 1});
                    rd_owed--;
                end
            end else if ($urandom_range(7) == 0) begin
                sd_rd_valid = 1'b1;
                sd_rd_data  = $urandom;
            end
            sd_wr_next  = 1'b0;
            wr_beat_exp = 1'b0;
            if (wr_owed > 0) begin
                if ($urandom_range(3) != 0) begin
                    sd_wr_next  = 1'b1;
                    wr_beat_exp = 1'b1;
                    wr_owed--;
                    wr_total_left--;
                    if (wr_total_left == 0) done_due = cyc + 1;
                end
            end else if ($urandom_range(7) == 0) begin
                sd_wr_next = 1'b1;
            end
            wr_data = $urandom;
            sd_cmd_ready = ($urandom_range(2) != 0);
            if (sd_cmd_valid && sd_cmd_ready) begin
                if (sd_cmd_write) wr_owed += int'(sd_cmd_length);
                else              rd_owed += int'(sd_cmd_length);
            end
        end
    end

    // Monitor: compares everything the DUT presents against the scoreboard
    cmd_t         m_cmd;
    rd_t          m_rd;
    bit           prev_stall = 1'b0;
    logic [33:0]  prev_cmd_bits = '0;
    initial forever begin
        @(negedge clk); #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("cmd_stable", {sd_cmd_valid, sd_cmd_write, sd_cmd_address, sd_cmd_length},
                      prev_cmd_bits);
            if (sd_cmd_valid && sd_cmd_ready) begin
                cmds_seen++;
                if (exp_cmd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got wr=%0d addr=%06h len=%0d, expected none",
                             sd_cmd_write, sd_cmd_address, sd_cmd_length);
                end else begin
                    m_cmd = exp_cmd.pop_front();
                    check("cmd", {sd_cmd_write, sd_cmd_address, sd_cmd_length},
                          {m_cmd.wr, m_cmd.addr, m_cmd.len});
                end
            end
            prev_stall    = sd_cmd_valid && !sd_cmd_ready;
            prev_cmd_bits = {sd_cmd_valid, sd_cmd_write, sd_cmd_address, sd_cmd_length};
            if (vid_rd_available) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got data %08h, expected none", vid_rd_data);
                end else begin
                    m_rd = exp_rd.pop_front();
                    check("rd_data", vid_rd_data, m_rd.data);
                    check("rd_latency", cyc, m_rd.cyc);
                end
            end
            if (sd_wr_next || wr_data_next)
                check("wr_data_next", wr_data_next, wr_beat_exp);
            if (wr_data_next) begin
                wr_beats++;
                check("sd_wr_data", sd_wr_data, wr_data);
            end
            if (wr_done) begin
                if (exp_done == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_done_unexpected: got 1 expected 0");
                end else begin
                    exp_done--;
                    check("wr_done_cycle", cyc, done_due);
                end
            end
        end
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    int            base;
    int            b0;
    int            len;
    logic [AW-1:0] a;
    initial begin
        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs", {vid_rd_available, vid_rd_data, wr_data_next, wr_done,
              sd_cmd_valid, sd_cmd_write, sd_cmd_address, sd_cmd_length, sd_wr_data,
              err_video_overrun}, 0);
        @(negedge clk); #1;
        reset = 1'b0;

        // Directed: video read 80 words at 0x100
        push_rd(23'h000100, 80);
        pulse(1, 23'h000100, 80, 0, 0, 0);
        drain("vid80");

        // Directed: 40-word write wrapping the top of memory
        b0 = wr_beats;
        start_write(23'h7FFFF8, 40);
        pulse(0, 0, 0, 1, 23'h7FFFF8, 40);
        drain("wr40");
        check("wr40_beats", wr_beats - b0, 40);

        // Chunk boundaries: exactly one chunk, and one word over
        b0 = wr_beats;
        start_write(23'h001230, 16);
        pulse(0, 0, 0, 1, 23'h001230, 16);
        drain("wr16");
        start_write(23'h003000, 17);
        pulse(0, 0, 0, 1, 23'h003000, 17);
        drain("wr17");
        check("wr16_17_beats", wr_beats - b0, 33);

        // Simultaneous requests: video first, then the whole write
        a = 23'($urandom);
        len = $urandom_range(17, 120);
        push_rd(23'h000200, 80);
        start_write(a, len);
        b0 = wr_beats;
        pulse(1, 23'h000200, 80, 1, a, len);
        drain("both");
        check("both_beats", wr_beats - b0, len);

        // Video request during chunk 2 slots in before chunk 3
        a = 23'($urandom);
        len = $urandom_range(33, 150);
        exp_cmd.push_back('{1'b1, a, 9'd16});
        exp_cmd.push_back('{1'b1, a + 23'd16, 9'd16});
        push_rd(23'h004400, 24);
        push_wr(a + 23'd32, len - 32);
        exp_done++;
        wr_total_left = len;
        b0 = wr_beats;
        base = cmds_seen;
        pulse(0, 0, 0, 1, a, len);
        wait_cmds(base + 2);
        pulse(1, 23'h004400, 24, 0, 0, 0);
        drain("vid_mid_wr");
        check("vid_mid_wr_beats", wr_beats - b0, len);

        // Zero-length requests issue nothing
        base = cmds_seen;
        pulse(1, 23'h000500, 0, 1, 23'h000600, 0);
        repeat (20) @(negedge clk);
        check("zero_len_cmds", cmds_seen - base, 0);
        check("err_before_overrun", err_video_overrun, 0);

        // Second video request during VID_DATA is dropped and flagged
        len = $urandom_range(20, 100);
        push_rd(23'h010000, len);
        base = cmds_seen;
        pulse(1, 23'h010000, len, 0, 0, 0);
        wait_cmds(base + 1);
        pulse(1, 23'h020000, 8, 0, 0, 0);
        drain("overrun");
        check("overrun_cmds", cmds_seen - base, 1);
        check("err_set", err_video_overrun, 1);

        // Random solo bursts
        for (int i = 0; i < 8; i++) begin
            a = 23'($urandom);
            if ($urandom_range(1) == 1) begin
                len = $urandom_range(1, 300);
                push_rd(a, len);
                pulse(1, a, len, 0, 0, 0);
                drain("rand_rd");
            end else begin
                len = $urandom_range(1, 200);
                b0 = wr_beats;
                start_write(a, len);
                pulse(0, 0, 0, 1, a, len);
                drain("rand_wr");
                check("rand_wr_beats", wr_beats - b0, len);
            end
        end
        check("err_sticky", err_video_overrun, 1);

        // Reset in the middle of a write: abandoned, no wr_done
        push_wr(23'h000040, 16);
        wr_total_left = 40;
        base = cmds_seen;
        pulse(0, 0, 0, 1, 23'h000040, 40);
        wait_cmds(base + 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset_mid_outputs", {vid_rd_available, vid_rd_data, wr_data_next, wr_done,
              sd_cmd_valid, sd_cmd_write, sd_cmd_address, sd_cmd_length, sd_wr_data,
              err_video_overrun}, 0);
        exp_cmd.delete();
        exp_rd.delete();
        @(negedge clk); #1;
        reset = 1'b0;
        base = cmds_seen;
        repeat (40) @(negedge clk);
        check("after_reset_cmds", cmds_seen - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter between the single SDRAM controller command port and its two clients: the video controller's burst read port and the terminal writer's burst write port. Video reads always win, so each character row is preloaded within its scanline. Writer bursts are cut into bounded chunks to limit the delay a video burst can see. Read data is returned to the video controller one registered cycle after the SDRAM delivers it.

## Interface
- `MAX_WRITE_CHUNK`, 16: maximum words per SDRAM write command; longer writer bursts are split.
- `ADDR_WIDTH`, 23: word address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- `clk` input 1: single clock, 108 MHz dot clock domain.
- `reset` input 1: synchronous, active-high.
- `vid_rd_request` input 1: one-cycle pulse, video read request.
- `vid_rd_address` input 23: video burst start address, sampled with the request.
- `vid_rd_burst_length` input 9: video burst words, sampled with the request.
- `vid_rd_available` output 1: `vid_rd_data` holds a valid word this cycle.
- `vid_rd_data` output 32: read word returned to the video port.
- `wr_request` input 1: one-cycle pulse, writer burst request.
- `wr_address` input 23: writer start address, sampled with the request.
- `wr_burst_length` input 9: writer words, sampled with the request.
- `wr_data_next` output 1: the writer must present the next word on `wr_data` in the same cycle.
- `wr_data` input 32: write word.
- `wr_done` output 1: one-cycle pulse after the last word of a writer burst.
- `sd_cmd_valid` output 1: command offered to the SDRAM controller.
- `sd_cmd_ready` input 1: the controller accepts the command when valid and ready are both high.
- `sd_cmd_write` output 1: 1 means write, 0 means read.
- `sd_cmd_address` output 23: command start address.
- `sd_cmd_length` output 9: command word count.
- `sd_rd_valid` input 1: read word present on `sd_rd_data`.
- `sd_rd_data` input 32: read word.
- `sd_wr_next` input 1: the controller consumes `sd_wr_data` this cycle.
- `sd_wr_data` output 32: combinational copy of `wr_data`.
- `err_video_overrun` output 1: sticky flag, cleared only by reset.

## Operation
- Pending latches:
  - `vid_rd_request` sets `vid_pend` and captures the video address and length.
  - `wr_request` sets `wr_pend` and captures `wr_addr` and `wr_remaining`.
  - A request pulse with length 0 is ignored and sets no pending flag.
- States: IDLE, VID_CMD, VID_DATA, WR_CMD, WR_DATA.
- IDLE:
  - If `vid_pend` → VID_CMD.
  - Else if `wr_pend` → WR_CMD.
  - When both are pending in the same cycle, video wins.
- VID_CMD:
  - Drives `sd_cmd_valid=1`, `sd_cmd_write=0`, the latched address and length.
  - On handshake: clear `vid_pend`, load `count`=length → VID_DATA.
- VID_DATA:
  - Each `sd_rd_valid` decrements `count` and forwards the word.
  - When `count` reaches 0 → IDLE.
- WR_CMD:
  - Drives `sd_cmd_write=1`, `sd_cmd_address=wr_addr`, `sd_cmd_length=min(wr_remaining, MAX_WRITE_CHUNK)`.
  - On handshake: load `count` with that chunk size → WR_DATA.
- WR_DATA:
  - `wr_data_next = sd_wr_next`, active in this state only.
  - Each beat decrements `count` and `wr_remaining` and increments `wr_addr` (wraps at 2^23).
  - When `count` reaches 0 and `wr_remaining` is 0: clear `wr_pend`, pulse `wr_done` → IDLE.
  - When `count` reaches 0 and `wr_remaining` is nonzero → IDLE, which gives a pending video request the next slot.
- A video request arriving while `vid_pend` is set or the state is VID_CMD/VID_DATA is dropped and sets `err_video_overrun`.
- A writer request arriving while `wr_pend` is set is dropped. The writer must wait for `wr_done`.
- `sd_rd_valid` outside VID_DATA is discarded.
- `sd_wr_next` outside WR_DATA is ignored, and `wr_data_next` stays 0.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Pending flags, counters and `err_video_overrun` cleared.
- Reset in the middle of a burst abandons it. No `wr_done` is issued for the abandoned burst.

## Timing
- Request pulse at cycle t: pending is set at t+1 and `sd_cmd_valid` rises at t+2 when the arbiter is idle.
- `sd_cmd_valid` and the command fields stay stable until `sd_cmd_ready`.
- Read path: `vid_rd_available` and `vid_rd_data` are registered. `sd_rd_valid` at cycle n gives `vid_rd_available` at n+1.
- Write path: `wr_data_next` and `sd_wr_data` are combinational, zero latency.
- `wr_done` is asserted in the cycle after the final `sd_wr_next`.
- After IDLE is re-entered, the next command is offered one cycle later.
- Worst-case video wait: one write chunk (≤ `MAX_WRITE_CHUNK` beats) plus 3 cycles plus controller latency.

## Test plan
- Video read, length 80, address 0x000100, `sd_cmd_ready` tied 1:
  - One read command with address 0x000100, length 80.
  - 80 `vid_rd_available` pulses, each one cycle after its `sd_rd_valid`, data identical.
- Writer burst of 40 words at 0x7FFFF8:
  - Commands of 16/16/8 at 0x7FFFF8, 0x000008, 0x000018.
  - 40 `wr_data_next` pulses, one `wr_done`.
- Video and writer request pulses in the same cycle:
  - The video read command is issued first.
  - The write command is issued only after 80 read words.
- Video request during the second chunk of a 40-word write:
  - The read command is issued immediately after chunk 2 completes.
  - Chunk 3 follows the read.
- Second `vid_rd_request` during VID_DATA:
  - Dropped, with no extra command.
  - `err_video_overrun`=1 and it stays set.
- Length 0 request: no command is issued. Reset asserted mid-write: all outputs 0, no `wr_done`.
